// File: rtl/ordering_xfer.sv
// ordering_xfer: moves replica orderings between the ordering array and host streams.
// Define ORDERING_XFER_CHECKSUM_EN to build the running byte-sum checksum.
module ordering_xfer #(
  parameter int replica_num = 32,
  parameter int beat_num    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_read,
  input  logic            start_write,
  output logic            busy,
  output logic            done,
  input  logic            ordering_ready,
  output logic            ordering_read,
  input  logic [7:0][7:0] ordering_rdata,
  output logic            ordering_write,
  output logic [7:0][7:0] ordering_wdata,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [63:0]     m_data,
  output logic            m_last,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [63:0]     s_data,
  output logic [15:0]     checksum
);

  localparam int T  = replica_num * beat_num;
  localparam int CW = $clog2(T + 1);
  localparam logic [CW-1:0] TOTAL = CW'(T);
  localparam logic [CW-1:0] LAST  = CW'(T - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    WRITE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] issued;
  logic [CW-1:0] delivered;
  logic [63:0]   fifo_mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    fifo_count;
  logic          inflight;
  logic          start_ok;
  logic          push;
  logic          pop;
  logic          drain_done;
  logic          done_q;

  assign start_ok = (state == IDLE) && (start_read || start_write);
  assign push     = inflight;
  assign m_valid  = fifo_count != 2'd0;
  assign m_data   = fifo_mem[rd_ptr];
  assign pop      = m_valid && m_ready;
  assign m_last   = m_valid && (delivered == LAST);
  assign busy     = state != IDLE;
  assign done     = drain_done || done_q;
  assign ordering_wdata = s_data;

  always_comb begin
    state_nx       = state;
    ordering_read  = 1'b0;
    ordering_write = 1'b0;
    s_ready        = 1'b0;
    drain_done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_read) begin
          state_nx = READ;
        end else if (start_write) begin
          state_nx = WRITE;
        end
      end
      READ: begin
        // fifo slots must cover the beat already in flight
        ordering_read = ordering_ready &&
                        (({1'b0, fifo_count} + {2'b0, inflight}) < 3'd2) &&
                        (issued < TOTAL);
        if (ordering_read && (issued == LAST)) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if ((fifo_count == 2'd0) && !inflight) begin
          drain_done = 1'b1;
          state_nx   = IDLE;
        end
      end
      WRITE: begin
        s_ready        = ordering_ready && (issued < TOTAL);
        ordering_write = s_valid && s_ready;
        if (ordering_write && (issued == LAST)) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      issued     <= '0;
      delivered  <= '0;
      inflight   <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
      done_q     <= 1'b0;
    end else begin
      state    <= state_nx;
      inflight <= ordering_read;
      done_q   <= ordering_write && (issued == LAST);
      if (start_ok) begin
        issued    <= '0;
        delivered <= '0;
      end else begin
        if (ordering_read || ordering_write) begin
          issued <= issued + CW'(1);
        end
        if (pop) begin
          delivered <= delivered + CW'(1);
        end
      end
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= ordering_rdata;
    end
  end

`ifdef ORDERING_XFER_CHECKSUM_EN
  logic [15:0] ck;

  function automatic logic [15:0] byte_sum(input logic [63:0] d);
    logic [15:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s = s + {8'h00, d[8*i +: 8]};
    end
    return s;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ck <= '0;
    end else if (start_ok) begin
      ck <= '0;
    end else if (pop) begin
      ck <= ck + byte_sum(m_data);
    end else if (ordering_write) begin
      ck <= ck + byte_sum(s_data);
    end
  end

  assign checksum = ck;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_ordering_xfer.sv
// tb_ordering_xfer: randomized scenarios for ordering_xfer
// against a queue-based model of the array and host streams.
module tb_ordering_xfer;

  localparam int RN = 2;
  localparam int BN = 2;
  localparam int T  = RN * BN;

  logic            clk;
  logic            reset;
  logic            start_read;
  logic            start_write;
  logic            busy;
  logic            done;
  logic            ordering_ready;
  logic            ordering_read;
  logic [7:0][7:0] ordering_rdata;
  logic            ordering_write;
  logic [7:0][7:0] ordering_wdata;
  logic            m_valid;
  logic            m_ready;
  logic [63:0]     m_data;
  logic            m_last;
  logic            s_valid;
  logic            s_ready;
  logic [63:0]     s_data;
  logic [15:0]     checksum;

  int          vec;
  int          errs;
  bit          pend;
  bit          just_ret;
  logic [63:0] exp_q [$];

  ordering_xfer #(
    .replica_num(RN),
    .beat_num   (BN)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start_read    (start_read),
    .start_write   (start_write),
    .busy          (busy),
    .done          (done),
    .ordering_ready(ordering_ready),
    .ordering_read (ordering_read),
    .ordering_rdata(ordering_rdata),
    .ordering_write(ordering_write),
    .ordering_wdata(ordering_wdata),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_last        (m_last),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .checksum      (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bsum(input logic [63:0] d);
    int s;
    s = 0;
    for (int i = 0; i < 8; i++) s += int'(d[8*i +: 8]);
    return s;
  endfunction

  function automatic logic [15:0] exp_ck(input int s);
    logic [15:0] v;
    v = s[15:0];
`ifndef ORDERING_XFER_CHECKSUM_EN
    v = 16'h0;
`endif
    return v;
  endfunction

  // array model: a beat requested last cycle is driven this cycle
  task automatic next_cycle();
    logic [63:0] rv;
    @(negedge clk);
    rv = {$urandom, $urandom};
    just_ret = pend;
    ordering_rdata = rv;
    if (pend) exp_q.push_back(rv);
  endtask

  task automatic settle();
    #1;
    pend = ordering_read;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start_read = 0; start_write = 0;
    ordering_ready = 0; m_ready = 0;
    s_valid = 0; s_data = '0; ordering_rdata = '0;
    pend = 0; just_ret = 0;
    repeat (2) @(negedge clk);
    #1;
    vec++;
    if ({busy, done, ordering_read, ordering_write, m_valid, m_last, s_ready} !== 7'b0) begin
      errs++;
      $display("FAIL reset_outs got %b want 0000000",
               {busy, done, ordering_read, ordering_write, m_valid, m_last, s_ready});
    end
    vec++;
    if (checksum !== 16'h0) begin
      errs++;
      $display("FAIL reset_ck got %h want 0000", checksum);
    end
    reset = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_read(input string nm, input int rdy_pct, input int mr_pct,
                           input bit stall10, input bit both);
    int issued, popped, stall, ck;
    bit last_pop, fin, avail;
    logic [63:0] hd;
    exp_q.delete();
    issued = 0; popped = 0; stall = 0; ck = 0;
    last_pop = 0; fin = 0;
    next_cycle();
    start_read = 1; start_write = both;
    ordering_ready = 1; m_ready = 1; s_valid = 0;
    settle();
    vec++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL %s.idle_busy got %b want 0", nm, busy);
    end
    for (int cyc = 0; cyc < 500 && !fin; cyc++) begin
      next_cycle();
      start_read = 0;
      start_write = both ? 1'($urandom_range(1)) : 1'b0;
      s_valid = 1'($urandom_range(1));
      s_data = {$urandom, $urandom};
      ordering_ready = $urandom_range(99) < rdy_pct;
      m_ready = $urandom_range(99) < mr_pct;
      if (stall10 && popped >= 1 && stall < 10) begin
        m_ready = 0;
        stall++;
      end
      settle();
      avail = exp_q.size() > int'(just_ret);
      vec++;
      if (checksum !== exp_ck(ck)) begin
        errs++;
        $display("FAIL %s.ck got %h want %h", nm, checksum, exp_ck(ck));
      end
      vec++;
      if (busy !== 1'b1) begin
        errs++;
        $display("FAIL %s.busy got %b want 1", nm, busy);
      end
      vec++;
      if (done !== last_pop) begin
        errs++;
        $display("FAIL %s.done got %b want %b", nm, done, last_pop);
      end
      vec++;
      if (m_valid !== avail) begin
        errs++;
        $display("FAIL %s.m_valid got %b want %b", nm, m_valid, avail);
      end
      vec++;
      if (m_last !== (avail && popped == T - 1)) begin
        errs++;
        $display("FAIL %s.m_last got %b want %b", nm, m_last, avail && popped == T - 1);
      end
      vec++;
      if (ordering_write !== 1'b0 || s_ready !== 1'b0) begin
        errs++;
        $display("FAIL %s.no_write got %b%b want 00", nm, ordering_write, s_ready);
      end
      vec++;
      if (ordering_read && (issued - popped >= 2 || issued >= T)) begin
        errs++;
        $display("FAIL %s.outstanding got %0d/%0d want <2/<%0d", nm,
                 issued - popped, issued, T);
      end
      if (last_pop) fin = 1;
      if (m_valid && m_ready && exp_q.size() > 0) begin
        hd = exp_q.pop_front();
        vec++;
        if (m_data !== hd) begin
          errs++;
          $display("FAIL %s.m_data got %h want %h", nm, m_data, hd);
        end
        ck += bsum(hd);
        popped++;
        if (popped == T) last_pop = 1;
      end
      if (ordering_read) issued++;
    end
    vec++;
    if (!fin) begin
      errs++;
      $display("FAIL %s.timeout got popped %0d want %0d", nm, popped, T);
    end
    next_cycle();
    start_write = 0; s_valid = 0;
    settle();
    vec++;
    if (busy !== 1'b0 || done !== 1'b0 || ordering_read !== 1'b0) begin
      errs++;
      $display("FAIL %s.end_idle got %b%b%b want 000", nm, busy, done, ordering_read);
    end
    vec++;
    if (issued != T || popped != T || exp_q.size() != 0) begin
      errs++;
      $display("FAIL %s.counts got %0d/%0d/%0d want %0d/%0d/0", nm,
               issued, popped, exp_q.size(), T, T);
    end
    vec++;
    if (checksum !== exp_ck(ck)) begin
      errs++;
      $display("FAIL %s.final_ck got %h want %h", nm, checksum, exp_ck(ck));
    end
  endtask

  task automatic test_write(input string nm, input int rdy_pct,
                            input bit directed, input bit gap5);
    int writes, gap, ck;
    bit last_wr, fin, exp_rdy, ck_seen;
    writes = 0; gap = 0; ck = 0;
    last_wr = 0; fin = 0; ck_seen = 0;
    next_cycle();
    start_write = 1; start_read = 0;
    ordering_ready = 1; s_valid = 0; m_ready = 0;
    settle();
    for (int cyc = 0; cyc < 500 && !fin; cyc++) begin
      next_cycle();
      start_write = 0;
      ordering_ready = $urandom_range(99) < rdy_pct;
      s_valid = $urandom_range(99) < 70;
      if (gap5 && writes == 2 && gap < 5) begin
        ordering_ready = 0;
        s_valid = 1;
        gap++;
      end
      if (directed && writes == 0) s_data = 64'h0102030405060708;
      else if (directed && writes == 1) s_data = 64'h1111111111111111;
      else s_data = {$urandom, $urandom};
      settle();
      exp_rdy = ordering_ready && writes < T;
      vec++;
      if (checksum !== exp_ck(ck)) begin
        errs++;
        $display("FAIL %s.ck got %h want %h", nm, checksum, exp_ck(ck));
      end
      if (directed && writes == 2 && !ck_seen) begin
        ck_seen = 1;
        vec++;
        if (checksum !== exp_ck(32'h00AC)) begin
          errs++;
          $display("FAIL %s.ck_ac got %h want %h", nm, checksum, exp_ck(32'h00AC));
        end
      end
      vec++;
      if (busy !== (writes < T)) begin
        errs++;
        $display("FAIL %s.busy got %b want %b", nm, busy, writes < T);
      end
      vec++;
      if (done !== last_wr) begin
        errs++;
        $display("FAIL %s.done got %b want %b", nm, done, last_wr);
      end
      vec++;
      if (s_ready !== exp_rdy) begin
        errs++;
        $display("FAIL %s.s_ready got %b want %b", nm, s_ready, exp_rdy);
      end
      vec++;
      if (ordering_write !== (s_valid && exp_rdy)) begin
        errs++;
        $display("FAIL %s.wr got %b want %b", nm, ordering_write, s_valid && exp_rdy);
      end
      vec++;
      if (ordering_read !== 1'b0 || m_valid !== 1'b0) begin
        errs++;
        $display("FAIL %s.no_read got %b%b want 00", nm, ordering_read, m_valid);
      end
      if (last_wr) fin = 1;
      if (ordering_write) begin
        vec++;
        if (ordering_wdata !== s_data) begin
          errs++;
          $display("FAIL %s.wdata got %h want %h", nm, ordering_wdata, s_data);
        end
        ck += bsum(s_data);
        writes++;
        if (writes == T) last_wr = 1;
      end
    end
    vec++;
    if (!fin || writes != T) begin
      errs++;
      $display("FAIL %s.writes got %0d want %0d", nm, writes, T);
    end
    if (gap5) begin
      vec++;
      if (gap != 5) begin
        errs++;
        $display("FAIL %s.gap got %0d want 5", nm, gap);
      end
    end
    vec++;
    if (checksum !== exp_ck(ck)) begin
      errs++;
      $display("FAIL %s.final_ck got %h want %h", nm, checksum, exp_ck(ck));
    end
    s_valid = 0;
  endtask

  task automatic test_reset_mid();
    int issued;
    issued = 0;
    exp_q.delete();
    next_cycle();
    start_read = 1; ordering_ready = 1; m_ready = 1;
    settle();
    for (int cyc = 0; cyc < 20 && issued < 1; cyc++) begin
      next_cycle();
      start_read = 0;
      settle();
      if (ordering_read) issued++;
    end
    next_cycle();
    settle();
    reset = 1'b0;
    #1;
    vec++;
    if ({busy, done, ordering_read, ordering_write, m_valid, m_last, s_ready} !== 7'b0) begin
      errs++;
      $display("FAIL mid_reset_outs got %b want 0000000",
               {busy, done, ordering_read, ordering_write, m_valid, m_last, s_ready});
    end
    vec++;
    if (checksum !== 16'h0) begin
      errs++;
      $display("FAIL mid_reset_ck got %h want 0000", checksum);
    end
    reset = 1'b1;
    pend = 0;
    exp_q.delete();
  endtask

  initial begin
    vec = 0;
    errs = 0;
    test_reset();
    test_read("rd_basic", 100, 100, 0, 0);
    test_read("rd_stall", 100, 100, 1, 0);
    test_read("rd_rand", 60, 50, 0, 0);
    test_read("rd_both", 80, 70, 0, 1);
    test_write("wr_directed", 100, 1, 0);
    test_write("wr_gap", 100, 1, 1);
    test_write("wr_rand", 60, 0, 0);
    test_read("rd_back_to_back", 70, 60, 0, 0);
    test_reset_mid();
    test_read("rd_after_rst", 100, 100, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
